// File: rtl/pipeline_pkg.sv
// Shared types for the RV32I pipeline: decode->execute and execute->memory
// bundles, ALU/multiply-divide opcodes and the execute-stage divider FSM states.
package pipeline_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  // Encoded as the RV32M funct3 so bit 2 marks divides, bit 1 remainders and
  // bit 0 the unsigned divide variants.
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } muldiv_op_e;

  typedef enum logic [1:0] {
    EX_IDLE, EX_BUSY, EX_DONE
  } ex_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] ImmExt;
    logic [XLEN-1:0] PCPlus4;
    logic [4:0]      Rd;
    logic [2:0]      funct3;
    alu_op_e         ALUControl;
    logic            ALUSrc;
    logic            MulDiv;
    muldiv_op_e      MulDivOp;
    logic            Branch;
    logic            Jump;
    logic            JumpReg;
    logic            RegWrite;
    logic            MemWrite;
    logic [1:0]      ResultSrc;
  } idex_t;

  typedef struct packed {
    logic [XLEN-1:0] ALUResult;
    logic [XLEN-1:0] WriteData;
    logic [XLEN-1:0] PCPlus4;
    logic [4:0]      Rd;
    logic            RegWrite;
    logic            MemWrite;
    logic [1:0]      ResultSrc;
  } exmem_t;

  // Absolute value when the operand is treated as signed, identity otherwise.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode-to-execute handshake: instruction bundle with valid, and the
// execute stage's ready back-pressure.
interface ex_stage_if;
  import pipeline_pkg::*;

  logic  in_valid;
  idex_t inputs;
  logic  in_ready;

  modport master (output in_valid, output inputs, input in_ready);
  modport slave  (input in_valid, input inputs, output in_ready);
endinterface

// File: rtl/div_unit.sv
// Iterative 32-step restoring divider on operand magnitudes with final sign
// fix-up. Present only when RV32M_EN is defined.
`ifdef RV32M_EN
module div_unit
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  ex_state_e       state, state_next;
  logic [4:0]      count;
  logic [XLEN-1:0] acc, quo, dvs;
  logic            neg_q, neg_r;
  logic [XLEN:0]   trial;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EX_IDLE;
    else        state <= state_next;
  end

  // NOTE: defaulting state_next before the case keeps this block free of latches.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EX_IDLE;
    end else begin
      unique case (state)
        EX_IDLE: if (start)       state_next = EX_BUSY;
        EX_BUSY: if (count == '0) state_next = EX_DONE;
        EX_DONE:                  state_next = EX_IDLE;
        default:                  state_next = EX_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == EX_BUSY);
    done = (state == EX_DONE);
  end

  // Borrow out of the 33-bit trial subtraction means the shifted partial
  // remainder is smaller than the divisor.
  assign trial = {acc, quo[XLEN-1]} - {1'b0, dvs};

  // NOTE: datapath registers are few and cheap, so they are reset too; an
  // aborted divide then leaves no stale partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      acc   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush) begin
      count <= '0;
    end else if (state == EX_IDLE && start) begin
      count <= 5'd31;
      acc   <= '0;
      quo   <= magnitude(dividend, is_signed);
      dvs   <= magnitude(divisor, is_signed);
      neg_q <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_r <= is_signed && dividend[XLEN-1];
    end else if (state == EX_BUSY) begin
      if (count != '0) count <= count - 5'd1;
      if (!trial[XLEN]) begin
        acc <= trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        acc <= {acc[XLEN-2:0], quo[XLEN-1]};
        quo <= {quo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -acc : acc;

endmodule
`endif

// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, ALU, branch/jump resolution and the EX/MEM
// register. Defining RV32M_EN adds single-cycle multiply and an iterative divide.
module ex_stage
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  ex_stage_if.slave       up,
  input  logic            flush,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output exmem_t          outputs
);

  idex_t           id;
  logic [XLEN-1:0] src_a, src_b, fwd_b, alu_res, ex_res, jump_base;
  logic            taken, in_ready_i, div_start, div_busy, div_done;
  exmem_t          ex_fields, div_out, next_out;

  assign id = up.inputs;

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = outputs.ALUResult;
      default: src_a = id.RD1;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = outputs.ALUResult;
      default: fwd_b = id.RD2;
    endcase
  end

  assign src_b = id.ALUSrc ? id.ImmExt : fwd_b;

  always_comb begin
    alu_res = '0;
    case (id.ALUControl)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLL:  alu_res = src_a << src_b[4:0];
      ALU_SRL:  alu_res = src_a >> src_b[4:0];
      ALU_SRA:  alu_res = $signed(src_a) >>> src_b[4:0];
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (id.funct3)
      F3_BEQ:  taken = (src_a == src_b);
      F3_BNE:  taken = (src_a != src_b);
      F3_BLT:  taken = ($signed(src_a) <  $signed(src_b));
      F3_BGE:  taken = ($signed(src_a) >= $signed(src_b));
      F3_BLTU: taken = (src_a <  src_b);
      F3_BGEU: taken = (src_a >= src_b);
      default: taken = 1'b0;
    endcase
  end

  assign PCSrcE    = up.in_valid & (id.Jump | (id.Branch & taken));
  assign jump_base = id.JumpReg ? src_a : id.PC;
  assign PCTargetE = (jump_base + id.ImmExt) & ~{{(XLEN-1){1'b0}}, id.JumpReg};

`ifdef RV32M_EN
  logic [XLEN:0]     mul_a, mul_b;
  logic [2*XLEN+1:0] prod;
  logic [XLEN-1:0]   md_res, div_q, div_r;
  logic              is_div, is_rem, div_signed, div_zero, div_ovf, div_rem;
  logic              unused_prod;
  exmem_t            div_hold;

  // Operands are sign- or zero-extended by one bit so one signed 33x33
  // product covers all four multiply flavours.
  assign mul_a = {(id.MulDivOp == MD_MULH || id.MulDivOp == MD_MULHSU) && src_a[XLEN-1], src_a};
  assign mul_b = {(id.MulDivOp == MD_MULH) && src_b[XLEN-1], src_b};
  assign prod  = {{(XLEN+1){mul_a[XLEN]}}, mul_a} * {{(XLEN+1){mul_b[XLEN]}}, mul_b};
  assign unused_prod = ^prod[2*XLEN+1:2*XLEN];

  assign is_div     = id.MulDivOp[2];
  assign is_rem     = id.MulDivOp[1];
  assign div_signed = ~id.MulDivOp[0];
  assign div_zero   = (src_b == '0);
  assign div_ovf    = div_signed && (src_a == 32'h8000_0000) && (&src_b);

  always_comb begin
    md_res = '0;
    case (id.MulDivOp)
      MD_MUL:                       md_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: md_res = prod[2*XLEN-1:XLEN];
      default: begin
        if (div_zero)     md_res = is_rem ? src_a : '1;
        else if (div_ovf) md_res = is_rem ? '0 : 32'h8000_0000;
      end
    endcase
  end

  assign ex_res     = id.MulDiv ? md_res : alu_res;
  assign in_ready_i = ~(div_busy | div_done);
  assign div_start  = in_ready_i & up.in_valid & id.MulDiv & is_div
                    & ~div_zero & ~div_ovf & ~flush;

  div_unit u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .flush     (flush),
    .dividend  (src_a),
    .divisor   (src_b),
    .is_signed (div_signed),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Writeback controls are captured at acceptance; the result is filled in
  // from the divider when it reaches DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_hold <= '0;
      div_rem  <= 1'b0;
    end else if (div_start) begin
      div_hold <= ex_fields;
      div_rem  <= is_rem;
    end
  end

  always_comb begin
    div_out           = div_hold;
    div_out.ALUResult = div_rem ? div_r : div_q;
  end
`else
  logic unused_md;

  assign unused_md  = ^{id.MulDiv, id.MulDivOp};
  assign ex_res     = alu_res;
  assign in_ready_i = 1'b1;
  assign div_start  = 1'b0;
  assign div_busy   = 1'b0;
  assign div_done   = 1'b0;
  assign div_out    = '0;
`endif

  assign up.in_ready = in_ready_i;

  always_comb begin
    ex_fields           = '0;
    ex_fields.ALUResult = ex_res;
    ex_fields.WriteData = fwd_b;
    ex_fields.PCPlus4   = id.PCPlus4;
    ex_fields.Rd        = id.Rd;
    ex_fields.RegWrite  = id.RegWrite;
    ex_fields.MemWrite  = id.MemWrite;
    ex_fields.ResultSrc = id.ResultSrc;
  end

  // Flush outranks everything; otherwise a finishing divide wins, and only an
  // idle, valid, non-stalling instruction passes through.
  always_comb begin
    next_out = '0;
    if (flush)                                       next_out = '0;
    else if (div_done)                               next_out = div_out;
    else if (up.in_valid && !div_busy && !div_start) next_out = ex_fields;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outputs <= '0;
    else        outputs <= next_out;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RV32I pipeline, with an optional iterative RV32M divide path. Consumes decoded `idex_t` bundles from decode, applies operand forwarding, computes ALU/branch/multiply/divide results, and registers them into an `exmem_t` bundle that feeds the memory stage. Divides stall upstream through a ready handshake and insert bubbles downstream while in progress.

## Interface
- No parameters; XLEN fixed at 32.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `inputs` holds a valid instruction.
- `inputs`  in  `idex_t`  decoded operands and controls: RD1, RD2, PC, ImmExt, PCPlus4, Rd, funct3, ALUControl, ALUSrc, MulDiv, MulDivOp, Branch, Jump, JumpReg, RegWrite, MemWrite, ResultSrc.
- `in_ready`  out  1  stage accepts `inputs` this cycle; low while a divide is busy.
- `flush`  in  1  kill the current EX instruction, including any in-flight divide.
- `ForwardAE`, `ForwardBE`  in  2  00 register-file value, 01 `ResultW`, 10 `outputs.ALUResult`; 11 behaves as 00.
- `ResultW`  in  32  writeback result.
- `PCSrcE`  out  1  redirect fetch (combinational).
- `PCTargetE`  out  32  redirect target (combinational).
- `outputs`  out  `exmem_t`  registered EX/MEM bundle.

## Operation
- SrcA = forwarded RD1. SrcB = ImmExt if ALUSrc, else forwarded RD2. WriteData = forwarded RD2.
- ALU: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU. Shift amount is SrcB[4:0].
- Branch compare by funct3: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- PCSrcE = in_valid & (Jump | (Branch & taken)).
- PCTargetE = (JumpReg ? SrcA : PC) + ImmExt, with bit 0 cleared when JumpReg is set.
- MUL/MULH/MULHSU/MULHU: single cycle, 64-bit product; low or high word selected per op.
- DIV/DIVU/REM/REMU: run in sub-module, 32-iteration restoring algorithm on magnitudes, signs fixed up at the end.
- Divide special cases finish in one cycle with no iteration:
  - divisor 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - signed 0x80000000 / −1: quotient = 0x80000000, remainder = 0.
- FSM states:
  - IDLE: a valid non-special divide, with no flush, latches its operands and controls and moves to BUSY.
  - BUSY: 5-bit counter runs 31 down to 0; at 0, moves to DONE.
  - DONE: writes the result into `outputs`, returns to IDLE.
- `in_ready` = 0 in BUSY and DONE, 1 in IDLE. Upstream holds `inputs` steady while `in_ready` = 0.
- A bubble is all controls cleared: RegWrite = MemWrite = 0, ResultSrc = 0.
- `outputs` loads a bubble when any of these holds:
  - `flush` is high;
  - `in_valid` is low in IDLE;
  - the FSM is in BUSY;
  - the FSM is in IDLE and is accepting a divide (moving to BUSY).
- `flush` has top priority: in any state it forces IDLE, clears the counter and loads a bubble.

## Timing
- Reset: `outputs` fully zero (a bubble), FSM in IDLE, counter 0, `in_ready` = 1.
- PCSrcE/PCTargetE are combinational from `inputs` and the forward muxes; `in_ready` is driven from the FSM state.
- ALU, branch, jump and multiply ops: result is in `outputs` one cycle after acceptance.
- Divide special cases: one cycle, same as the ALU.
- Normal divide:
  - accept at edge N;
  - BUSY covers edges N+1..N+32;
  - DONE writes `outputs` at edge N+33, which is 34-cycle latency;
  - `in_ready` rises in the cycle after that edge.
- Forward path 10 uses the value already held in `outputs`, so an op directly after a divide forwards the divide result.
- `rst_n` assertion mid-divide aborts immediately, with no partial result.

## Configuration
- `RV32M_EN` defined: multiply, divide, the FSM and the `div_unit` instance are all present.
- `RV32M_EN` undefined:
  - MulDiv is ignored and the instruction executes as its ALUControl op;
  - `in_ready` is tied to 1;
  - no FSM or divider logic exists;
  - every instruction has single-cycle latency.

## Structure
- `pipeline_pkg` holds `idex_t`, `exmem_t`, the `alu_op_e` and `muldiv_op_e` enums, and the `ex_state_e` FSM enum.
- Sub-module `div_unit` contains the iterative divider: start/busy/done handshake, operands, signed flag; outputs quotient and remainder.
- Forward muxes, ALU, multiplier and branch logic live in `ex_stage`.

## Test plan
- ADD with Rd = 5, RD1 = 7, RD2 = 3 -> next cycle ALUResult = 10, RegWrite = 1, Rd = 5.
- BLT with RD1 = 0xFFFFFFFF, RD2 = 1, PC = 0x100, Imm = 0x20 -> PCSrcE = 1, PCTargetE = 0x120. The same operands with BLTU -> PCSrcE = 0.
- DIV −7 / 2 -> `in_ready` low for 33 cycles with bubbles in `outputs`, then ALUResult = 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF.
- DIVU 5 / 0 -> single cycle, 0xFFFFFFFF. DIV 0x80000000 / −1 -> single cycle, 0x80000000.
- `flush` asserted 10 cycles into a divide -> `in_ready` = 1 the next cycle, `outputs` is a bubble, and a following ADD completes normally.
- ForwardAE = 01 with ResultW = 0x40, RD1 = 0, ADDI with imm 4 -> ALUResult = 0x44. Assert `rst_n` low mid-divide -> `outputs` zero, `in_ready` = 1.
